seg7_scan_mux: RTL and testbench
================================

# seg7_scan_mux

Parametrised, time-multiplexed seven-segment display driver for an N-digit common-anode display. It takes per-digit 5-bit symbol codes, decimal points, per-digit enable and blink masks, and drives active-low segment and anode lines. Digits are scanned at a programmable prescaled rate. It adds digit-count/rate generics, an extended glyph set, blinking, leading-zero blanking, a frame strobe, and a defined reset state. It sits between the clock/score logic and the board pins.

## Interface
- NUM_DIGITS, 4, digits driven (1..8)
- SCAN_DIV, 16, clk cycles each digit is held (>=1)
- BLINK_DIV, 64, scan frames per blink half-period (>=1)
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- codes  in  5*NUM_DIGITS  symbol code per digit; digit i in bits [5i+4:5i]; digit 0 = rightmost
- dp  in  NUM_DIGITS  1 = light decimal point of digit i
- digit_en  in  NUM_DIGITS  0 = digit i always blank
- blink_mask  in  NUM_DIGITS  1 = digit i blanked during blink off-phase
- lzb  in  1  leading-zero blanking enable
- seg  out  8  active-low {dp,g,f,e,d,c,b,a}
- an  out  NUM_DIGITS  active-low anode select, at most one low
- frame_done  out  1  one-cycle pulse when digit 0 is loaded

## Operation
- Prescaler `pcnt` counts 0..SCAN_DIV-1 and wraps. `tick` = (pcnt == SCAN_DIV-1).
- Digit index `idx` moves only on tick: next = (idx==0) ? NUM_DIGITS-1 : idx-1. The scan runs leftmost to rightmost.
- On a tick edge, seg/an are registered from the new idx and the current inputs. There is no frame-level snapshot of the inputs.
- Glyph map, as seg hex with dp off:
  - 0:C0 1:F9 2:A4 3:B0 4:99 5:92 6:82 7:F8 8:80 9:90
  - 10 A:88 11 b:83 12 C:C6 13 d:A1 14 E:86 15 F:8E
  - 16 L:C7 17 P:8C 18 Y:91 19 '-':BF 20 H:89 21 U:C1
  - 22..31: blank, FF
- dp[i]=1 clears seg[7], unless the digit is blanked.
- Digit i is blanked when any of these holds:
  - digit_en[i]=0
  - blink_phase=1 and blink_mask[i]=1
  - lzb=1, i>0, and codes of all digits j>=i equal 0
- A blanked digit drives seg=FF and keeps an all ones, so no anode is asserted in that slot.
- Digit 0 is never blanked by lzb. An all-zero value with lzb=1 shows a single "0".
- Blink: frame counter `fcnt` increments on each frame_done. At BLINK_DIV-1 it wraps to 0 and toggles blink_phase.
- NUM_DIGITS=1: idx stays 0, and every tick is a frame.

## Timing
- Reset (async assert, synchronous release): pcnt=0, idx=0, fcnt=0, blink_phase=0, seg=FF, an=all ones, frame_done=0.
- The first tick occurs SCAN_DIV cycles after reset release. At that edge digit NUM_DIGITS-1 is loaded. Outputs are blank before that.
- Each digit is held exactly SCAN_DIV cycles. A frame lasts NUM_DIGITS*SCAN_DIV cycles.
- frame_done is high for the cycle following the edge that loads digit 0.
- Input changes appear at the next tick that selects the affected digit, within at most NUM_DIGITS*SCAN_DIV cycles.
- blink_phase toggles on the edge after the BLINK_DIV-th frame_done. The blink period is 2*BLINK_DIV frames.
- Reset asserted mid-frame returns all outputs to reset values immediately. The scan restarts from the reset sequence.
- SCAN_DIV=1: tick is every cycle, and the digit advances every clock.

## Test plan
- NUM_DIGITS=4, SCAN_DIV=4, codes={1,2,3,4}, all enabled, lzb=0 -> reset pattern holds for 4 cycles; then an = 0111/F9, 1011/A4, 1101/B0, 1110/99, each held 4 cycles; frame_done pulses once per 16 cycles.
- codes={0,0,7,0}, lzb=1 -> digits 3 and 2 blank (an=1111, seg=FF); digit 1 shows F8; digit 0 shows C0. With all codes 0 -> only digit 0 shows C0.
- dp=0010, codes digit1=5 -> digit 1 seg=12; with digit_en[1]=0 the same slot gives seg=FF and an=1111.
- BLINK_DIV=2, blink_mask=0001, codes digit0=E -> digit 0 shows 86 for 2 frames, blank for 2 frames, repeating; other digits unaffected.
- Codes 19, 21, 25 -> BF, C1, FF respectively.
- rst_n pulsed low mid-digit (async, not clock-aligned) -> seg=FF, an=all ones, frame_done=0 within the same cycle; after release, the first digit loads SCAN_DIV cycles later.

Source files
------------

// File: rtl/seg7_scan_mux.sv
// seg7_scan_mux
//   Time-multiplexed driver for an N-digit common-anode seven-segment display.
//   A prescaler advances the digit index every SCAN_DIV clocks, scanning from
//   the leftmost digit (NUM_DIGITS-1) down to digit 0. On each advance the
//   segment and anode lines are registered from the newly selected digit
//   and the live inputs. Supports an extended glyph set, per-digit enable,
//   blinking, and leading-zero blanking. It also emits a frame strobe.
//
// Ports
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   codes       5-bit symbol per digit, digit i at [5i+4:5i], digit 0 rightmost
//   dp          per-digit decimal point, 1 = lit
//   digit_en    per-digit enable, 0 = always blank
//   blink_mask  per-digit blink enable, 1 = blank during blink off-phase
//   lzb         leading-zero blanking enable
//   seg         active-low {dp,g,f,e,d,c,b,a}
//   an          active-low anode select, at most one low
//   frame_done  one-cycle pulse after the edge that loads digit 0
module seg7_scan_mux #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 16,
  parameter int BLINK_DIV  = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [5*NUM_DIGITS-1:0] codes,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  input  logic                    lzb,
  output logic [7:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);
  localparam logic [PW-1:0] PCNT_LAST = PW'(SCAN_DIV - 1);
  localparam logic [FW-1:0] FCNT_LAST = FW'(BLINK_DIV - 1);

  // Full 8-bit active-low pattern with the decimal point off.
  function automatic logic [7:0] glyph(input logic [4:0] code);
    logic [7:0] pat;
    case (code)
      5'd0:    pat = 8'hC0;
      5'd1:    pat = 8'hF9;
      5'd2:    pat = 8'hA4;
      5'd3:    pat = 8'hB0;
      5'd4:    pat = 8'h99;
      5'd5:    pat = 8'h92;
      5'd6:    pat = 8'h82;
      5'd7:    pat = 8'hF8;
      5'd8:    pat = 8'h80;
      5'd9:    pat = 8'h90;
      5'd10:   pat = 8'h88;  // A
      5'd11:   pat = 8'h83;  // b
      5'd12:   pat = 8'hC6;  // C
      5'd13:   pat = 8'hA1;  // d
      5'd14:   pat = 8'h86;  // E
      5'd15:   pat = 8'h8E;  // F
      5'd16:   pat = 8'hC7;  // L
      5'd17:   pat = 8'h8C;  // P
      5'd18:   pat = 8'h91;  // Y
      5'd19:   pat = 8'hBF;  // -
      5'd20:   pat = 8'h89;  // H
      5'd21:   pat = 8'hC1;  // U
      default: pat = 8'hFF;
    endcase
    return pat;
  endfunction

  logic [PW-1:0]         pcnt;
  logic [PW-1:0]         pcnt_nxt;
  logic [IW-1:0]         idx;
  logic [IW-1:0]         idx_nxt;
  logic [FW-1:0]         fcnt;
  logic                  blink_phase;
  logic                  tick;
  logic [NUM_DIGITS-1:0] blank;
  logic [7:0]            seg_sel;
  logic [NUM_DIGITS-1:0] an_sel;

  always_comb begin : scan_next
    tick     = (pcnt == PCNT_LAST);
    pcnt_nxt = tick ? '0 : pcnt + 1'b1;
    idx_nxt  = idx;
    if (tick) begin
      idx_nxt = (idx == '0) ? IDX_LAST : idx - 1'b1;
    end
  end

  // Walk from the leftmost digit down so all_zero means "this digit and
  // everything to its left is code 0". Digit 0 is exempt from lzb so an
  // all-zero value still shows a single 0.
  always_comb begin : blanking
    logic all_zero;
    all_zero = 1'b1;
    blank    = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      all_zero = all_zero & (codes[5*i +: 5] == 5'd0);
      blank[i] = ~digit_en[i]
               | (blink_phase & blink_mask[i])
               | (lzb & (i > 0) & all_zero);
    end
  end

  // Selection by compare loop rather than array index keeps non-power-of-2
  // digit counts free of out-of-range indexing.
  always_comb begin : select
    seg_sel = 8'hFF;
    an_sel  = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if ((idx_nxt == IW'(i)) && !blank[i]) begin
        seg_sel   = glyph(codes[5*i +: 5]) & ~{dp[i], 7'b0};
        an_sel[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt        <= '0;
      idx         <= '0;
      fcnt        <= '0;
      blink_phase <= 1'b0;
      seg         <= 8'hFF;
      an          <= '1;
      frame_done  <= 1'b0;
    end else begin
      pcnt       <= pcnt_nxt;
      frame_done <= tick && (idx_nxt == '0);
      if (tick) begin
        idx <= idx_nxt;
        seg <= seg_sel;
        an  <= an_sel;
      end
      if (frame_done) begin
        if (fcnt == FCNT_LAST) begin
          fcnt        <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          fcnt <= fcnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_mux.sv
module tb_seg7_scan_mux;

  localparam int ND = 4;
  localparam int SD = 4;
  localparam int BD = 2;
  localparam int FRAME = ND * SD;

  localparam logic [7:0] GL [32] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E,
    8'hC7, 8'h8C, 8'h91, 8'hBF, 8'h89, 8'hC1, 8'hFF, 8'hFF,
    8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF
  };

  logic          clk;
  logic          rst_n;
  logic [5*ND-1:0] codes;
  logic [ND-1:0] dp, digit_en, blink_mask;
  logic          lzb;
  logic [7:0]    seg;
  logic [ND-1:0] an;
  logic          frame_done;

  logic [4:0]    codes1;
  logic [0:0]    dp1, en1, bm1;
  logic          lzb1;
  logic [7:0]    seg1;
  logic [0:0]    an1;
  logic          fd1;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic [11:0] last;
  logic [11:0] sb [$];
  logic [8:0]  sb1 [$];
  logic [8:0]  last1;

  seg7_scan_mux #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .BLINK_DIV(BD)) dut (
    .clk(clk), .rst_n(rst_n), .codes(codes), .dp(dp), .digit_en(digit_en),
    .blink_mask(blink_mask), .lzb(lzb), .seg(seg), .an(an),
    .frame_done(frame_done)
  );

  seg7_scan_mux #(.NUM_DIGITS(1), .SCAN_DIV(1), .BLINK_DIV(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .codes(codes1), .dp(dp1), .digit_en(en1),
    .blink_mask(bm1), .lzb(lzb1), .seg(seg1), .an(an1), .frame_done(fd1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Blink phase seen by a load at edge e (edges counted from reset release).
  function automatic bit model_phase(input int e);
    return bit'(((e - 1) / (FRAME * BD)) % 2);
  endfunction

  function automatic logic [11:0] exp_out(input int d, input bit ph);
    logic [7:0] s;
    logic       z;
    logic [3:0] a;
    z = 1'b1;
    for (int j = d; j < ND; j++) if (codes[5*j +: 5] != 5'd0) z = 1'b0;
    if (!digit_en[d] || (ph && blink_mask[d]) || (lzb && d > 0 && z))
      return {4'hF, 8'hFF};
    s = GL[codes[5*d +: 5]];
    if (dp[d]) s[7] = 1'b0;
    a = 4'hF;
    a[d] = 1'b0;
    return {a, s};
  endfunction

  // Called with cyc on a frame boundary; inputs are already set for the frame.
  task automatic run_frame(input string tag);
    for (int k = 0; k < ND; k++)
      sb.push_back(exp_out(ND - 1 - k, model_phase(cyc + SD * (k + 1))));
    for (int c = 0; c < FRAME; c++) begin
      @(posedge clk);
      cyc++;
      #1;
      if (cyc % SD == 0) begin
        if (sb.size() != 0) last = sb.pop_front();
        else begin
          errors++;
          $error("FAIL %s_sb_underflow observed=0 expected=1", tag);
        end
      end
      check({tag, "_out"}, 32'({an, seg}), 32'(last));
      check({tag, "_fd"}, 32'(frame_done), 32'((cyc % FRAME) == 0));
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    codes      = {5'd1, 5'd2, 5'd3, 5'd4};
    dp         = '0;
    digit_en   = '1;
    blink_mask = '0;
    lzb        = 1'b0;
    codes1     = 5'd8;
    dp1        = 1'b0;
    en1        = 1'b1;
    bm1        = 1'b0;
    lzb1       = 1'b0;
    last       = {4'hF, 8'hFF};
    repeat (3) @(negedge clk);
    check("rst_seg", 32'(seg), 32'hFF);
    check("rst_an", 32'(an), 32'hF);
    check("rst_fd", 32'(frame_done), 32'h0);
    check("rst1_out", 32'({an1, seg1}), 32'h1FF);
    rst_n = 1'b1;
    cyc   = 0;

    run_frame("basic0");
    run_frame("basic1");

    // Single-digit, every-clock scan: each edge loads digit 0 and is a frame.
    for (int k = 0; k < FRAME; k++) begin
      codes1 = 5'(k);
      dp1    = 1'(k & 1);
      lzb1   = 1'b1;
      last1  = {1'b0, GL[k] & ~{dp1, 7'b0}};
      sb1.push_back(last1);
      @(posedge clk);
      cyc++;
      #1;
      last1 = sb1.pop_front();
      check("one_out", 32'({an1, seg1}), 32'(last1));
      check("one_fd", 32'(fd1), 32'h1);
    end

    codes = {5'd0, 5'd0, 5'd7, 5'd0};
    lzb   = 1'b1;
    run_frame("lzb_0070");
    codes = '0;
    run_frame("lzb_zero");

    lzb   = 1'b0;
    codes = {5'd8, 5'd9, 5'd5, 5'd10};
    dp    = 4'b0010;
    run_frame("dp");
    digit_en = 4'b1101;
    run_frame("en_off");

    digit_en = '1;
    dp       = '0;
    codes    = {5'd19, 5'd21, 5'd25, 5'd0};
    run_frame("glyph_ext");

    codes      = {5'd1, 5'd2, 5'd3, 5'd14};
    blink_mask = 4'b0001;
    for (int f = 0; f < 5; f++) run_frame("blink");

    // frame_done is high here; assert reset off the clock grid.
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_seg", 32'(seg), 32'hFF);
    check("arst_an", 32'(an), 32'hF);
    check("arst_fd", 32'(frame_done), 32'h0);
    check("arst1_out", 32'({fd1, an1, seg1}), 32'h1FF);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cyc   = 0;
    last  = {4'hF, 8'hFF};
    blink_mask = '0;
    run_frame("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
